multiplexador_varredura: RTL and testbench

//  Registered, parametrised N:1 word multiplexer; successor to the 8x8-bit combinational mux.
//  Two modes: MANUAL (external selector) and VARREDURA (auto round-robin scan over enabled channels).

---
 rtl/mux_pkg.sv | 19 +
 rtl/arbitro_rotativo.sv | 36 +++
 rtl/multiplexador_varredura.sv | 138 +++++++++++++
 tb/tb_multiplexador_varredura.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types and constants for the scanning word multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    typedef enum logic [1:0] {
        LIVRE  = 2'd0,
        ESPERA = 2'd1,
        PAUSA  = 2'd2
    } estado_t;

    localparam logic MODO_MANUAL    = 1'b0;
    localparam logic MODO_VARREDURA = 1'b1;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/arbitro_rotativo.sv
`default_nettype none
// ============================================================================
//  Module      : arbitro_rotativo
//  Description : Combinational round-robin search for the next enabled channel
//                after ptr, wrapping from CANAIS-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbitro_rotativo #(
    parameter  int CANAIS = 8,
    localparam int SEL_W  = $clog2(CANAIS)
) (
    input  logic [CANAIS-1:0] mascara,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  nxt,
    output logic              achou
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset to the nearest so the closest hit wins;
    // offset CANAIS lets ptr itself be chosen when it is the only one enabled.
    always_comb begin
        nxt   = '0;
        achou = 1'b0;
        idx   = '0;
        for (int k = CANAIS; k >= 1; k--) begin
            idx = SEL_W'((int'(ptr) + k) % CANAIS);
            if (mascara[idx]) begin
                nxt   = idx;
                achou = 1'b1;
            end
        end
    end

endmodule : arbitro_rotativo
`default_nettype wire

// File: rtl/multiplexador_varredura.sv
`default_nettype none
// ============================================================================
//  Module      : multiplexador_varredura
//  Description : Registered N:1 word multiplexer with manual selection or
//                round-robin scan with dwell, valid/ready output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplexador_varredura
    import mux_pkg::*;
#(
    parameter  int LARGURA = 8,
    parameter  int CANAIS  = 8,
    parameter  int CONT_W  = 8,
    localparam int SEL_W   = $clog2(CANAIS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CANAIS-1:0][LARGURA-1:0]  entrada,
    input  logic [CANAIS-1:0]               habilita_canal,
    input  logic                            modo,
    input  logic [SEL_W-1:0]                seletor,
    input  logic [CONT_W-1:0]               permanencia,
    output logic [LARGURA-1:0]              saida,
    output logic [SEL_W-1:0]                canal_saida,
    output logic                            saida_valida,
    input  logic                            saida_pronta,
    output logic                            erro_sel
);

    estado_t             estado;
    logic [SEL_W-1:0]    ptr;
    logic [CONT_W-1:0]   cnt;

    logic [SEL_W-1:0]    nxt;
    logic                achou;
    logic                aceite;
    logic                sel_ok;
    logic                executa_livre;
    logic                cap;
    logic                erro;
    logic [SEL_W-1:0]    canal_cap;

    arbitro_rotativo #(
        .CANAIS (CANAIS)
    ) u_arbitro (
        .mascara (habilita_canal),
        .ptr     (ptr),
        .nxt     (nxt),
        .achou   (achou)
    );

    assign aceite = saida_valida & saida_pronta;

    // Decision a free slot would take this cycle ("act as LIVRE").
    always_comb begin
        sel_ok    = 1'b0;
        cap       = 1'b0;
        erro      = 1'b0;
        canal_cap = seletor;
        if ({1'b0, seletor} < (SEL_W + 1)'(CANAIS)) begin
            sel_ok = habilita_canal[seletor];
        end
        if (modo == MODO_MANUAL) begin
            if (sel_ok) begin
                cap = 1'b1;
            end else begin
                erro = 1'b1;
            end
        end else if (achou) begin
            cap       = 1'b1;
            canal_cap = nxt;
        end
    end

    // The final dwell cycle captures directly so exactly permanencia idle
    // cycles separate two scan words.
    always_comb begin
        executa_livre = 1'b0;
        case (estado)
            LIVRE:   executa_livre = 1'b1;
            ESPERA:  executa_livre = aceite &
                                     ((modo == MODO_MANUAL) || (permanencia == '0));
            PAUSA:   executa_livre = (modo == MODO_VARREDURA) && (cnt <= CONT_W'(1));
            default: executa_livre = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= LIVRE;
            ptr          <= SEL_W'(CANAIS - 1);
            cnt          <= '0;
            saida        <= '0;
            canal_saida  <= '0;
            saida_valida <= 1'b0;
            erro_sel     <= 1'b0;
        end else begin
            erro_sel <= 1'b0;
            if (executa_livre) begin
                erro_sel <= erro;
                cnt      <= '0;
                if (cap) begin
                    saida        <= entrada[canal_cap];
                    canal_saida  <= canal_cap;
                    saida_valida <= 1'b1;
                    estado       <= ESPERA;
                    if (modo == MODO_VARREDURA) begin
                        ptr <= nxt;
                    end
                end else begin
                    saida_valida <= 1'b0;
                    estado       <= LIVRE;
                end
            end else begin
                case (estado)
                    ESPERA: begin
                        if (aceite) begin
                            saida_valida <= 1'b0;
                            cnt          <= permanencia;
                            estado       <= PAUSA;
                        end
                    end
                    PAUSA: begin
                        if (modo == MODO_MANUAL) begin
                            cnt    <= '0;
                            estado <= LIVRE;
                        end else begin
                            cnt <= cnt - CONT_W'(1);
                        end
                    end
                    default: estado <= LIVRE;
                endcase
            end
        end
    end

endmodule : multiplexador_varredura
`default_nettype wire

// File: tb/tb_multiplexador_varredura.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplexador_varredura
//  Description : Scoreboard bench: stimulus queues expected words, a negedge
//                monitor pops and compares whenever a DUT presents a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplexador_varredura;

    typedef struct {
        logic [2:0] canal;
        logic [7:0] dado;
        int         gap;
    } esp_t;

    logic            clk = 1'b0;
    logic            rst_n;

    logic [7:0][7:0] entrada8;
    logic [7:0]      mask8;
    logic            modo8;
    logic [2:0]      sel8;
    logic [7:0]      perm8;
    logic [7:0]      saida8;
    logic [2:0]      canal8;
    logic            valida8;
    logic            pronta8;
    logic            erro8;

    logic [5:0][7:0] entrada6;
    logic [5:0]      mask6;
    logic            modo6;
    logic [2:0]      sel6;
    logic [7:0]      perm6;
    logic [7:0]      saida6;
    logic [2:0]      canal6;
    logic            valida6;
    logic            pronta6;
    logic            erro6;

    esp_t q8[$];
    esp_t q6[$];
    int   qe6[$];
    esp_t e8, e6;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   ver_reset = 1'b0;
    bit   fim = 1'b0;
    bit   done = 1'b0;

    bit         v8_ant = 1'b0, ac8_ant = 1'b0, v6_ant = 1'b0, ac6_ant = 1'b0;
    int         gap8 = 0;
    logic [7:0] h_dado8 = '0;
    logic [2:0] h_canal8 = '0;

    always #5 clk = ~clk;

    multiplexador_varredura #(.LARGURA(8), .CANAIS(8), .CONT_W(8)) dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .entrada        (entrada8),
        .habilita_canal (mask8),
        .modo           (modo8),
        .seletor        (sel8),
        .permanencia    (perm8),
        .saida          (saida8),
        .canal_saida    (canal8),
        .saida_valida   (valida8),
        .saida_pronta   (pronta8),
        .erro_sel       (erro8)
    );

    multiplexador_varredura #(.LARGURA(8), .CANAIS(6), .CONT_W(8)) dut6 (
        .clk            (clk),
        .rst_n          (rst_n),
        .entrada        (entrada6),
        .habilita_canal (mask6),
        .modo           (modo6),
        .seletor        (sel6),
        .permanencia    (perm6),
        .saida          (saida6),
        .canal_saida    (canal6),
        .saida_valida   (valida6),
        .saida_pronta   (pronta6),
        .erro_sel       (erro6)
    );

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            v8_ant = 1'b0; ac8_ant = 1'b0; gap8 = 0;
            v6_ant = 1'b0; ac6_ant = 1'b0;
            if (ver_reset) begin
                n_cmp++;
                if (saida8 !== 8'h00 || canal8 !== 3'd0 || valida8 !== 1'b0 || erro8 !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_dut8: saida=%h canal=%0d valida=%b erro=%b, required all 0",
                             saida8, canal8, valida8, erro8);
                end
                n_cmp++;
                if (saida6 !== 8'h00 || canal6 !== 3'd0 || valida6 !== 1'b0 || erro6 !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_dut6: saida=%h canal=%0d valida=%b erro=%b, required all 0",
                             saida6, canal6, valida6, erro6);
                end
            end
        end else begin
            n_cmp++;
            if (erro8 !== 1'b0) begin
                n_err++;
                $display("FAIL erro_dut8: erro_sel=%b, required 0", erro8);
            end
            if (valida8) begin
                if (!v8_ant || ac8_ant) begin
                    n_cmp++;
                    if (q8.size() == 0) begin
                        n_err++;
                        $display("FAIL word_dut8: unexpected canal=%0d saida=%h, required no word",
                                 canal8, saida8);
                    end else begin
                        e8 = q8.pop_front();
                        if (canal8 !== e8.canal || saida8 !== e8.dado ||
                            (e8.gap >= 0 && gap8 != e8.gap)) begin
                            n_err++;
                            $display("FAIL word_dut8: canal=%0d saida=%h gap=%0d, required canal=%0d saida=%h gap=%0d",
                                     canal8, saida8, gap8, e8.canal, e8.dado, e8.gap);
                        end
                    end
                    h_canal8 = canal8;
                    h_dado8  = saida8;
                end else begin
                    n_cmp++;
                    if (canal8 !== h_canal8 || saida8 !== h_dado8) begin
                        n_err++;
                        $display("FAIL hold_dut8: canal=%0d saida=%h, required canal=%0d saida=%h",
                                 canal8, saida8, h_canal8, h_dado8);
                    end
                end
                gap8 = 0;
            end else begin
                if (v8_ant && !ac8_ant) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL hold_valid_dut8: valida=0, required 1 (word not accepted)");
                end
                gap8++;
            end
            ac8_ant = valida8 & pronta8;
            v8_ant  = valida8;

            if (erro6) begin
                n_cmp++;
                if (qe6.size() == 0 || valida6 !== 1'b0) begin
                    n_err++;
                    $display("FAIL erro_dut6: pulse with valida=%b pending=%0d, required expected pulse and valida=0",
                             valida6, qe6.size());
                end
                if (qe6.size() != 0) void'(qe6.pop_front());
            end
            if (valida6 && (!v6_ant || ac6_ant)) begin
                n_cmp++;
                if (q6.size() == 0) begin
                    n_err++;
                    $display("FAIL word_dut6: unexpected canal=%0d saida=%h, required no word",
                             canal6, saida6);
                end else begin
                    e6 = q6.pop_front();
                    if (canal6 !== e6.canal || saida6 !== e6.dado) begin
                        n_err++;
                        $display("FAIL word_dut6: canal=%0d saida=%h, required canal=%0d saida=%h",
                                 canal6, saida6, e6.canal, e6.dado);
                    end
                end
            end
            ac6_ant = valida6 & pronta6;
            v6_ant  = valida6;
        end

        if (fim && !done) begin
            n_cmp++;
            if (q8.size() != 0 || q6.size() != 0 || qe6.size() != 0) begin
                n_err++;
                $display("FAIL leftover: q8=%0d q6=%0d erro6=%0d still pending, required 0",
                         q8.size(), q6.size(), qe6.size());
            end
            done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic esp8(input logic [2:0] c, input logic [7:0] d, input int g);
        q8.push_back('{canal: c, dado: d, gap: g});
    endtask

    task automatic espera_fila();
        for (int c = 0; c < 100; c++) begin
            if (q8.size() == 0) break;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) entrada8[i] = 8'h10 + 8'(i);
        for (int i = 0; i < 6; i++) entrada6[i] = 8'h10 + 8'(i);
        rst_n = 1'b1;
        modo8 = 1'b1; mask8 = 8'h00; sel8 = 3'd0; perm8 = 8'd0; pronta8 = 1'b1;
        modo6 = 1'b1; mask6 = 6'h00; sel6 = 3'd0; perm6 = 8'd0; pronta6 = 1'b1;
        ver_reset = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        ver_reset = 1'b0;
        rst_n = 1'b1;
        step();

        // T4: CANAIS=6, out-of-range then masked selector, then a legal one
        modo6 = 1'b0; mask6 = 6'b10_1111; sel6 = 3'd7; qe6.push_back(7);
        step();
        sel6 = 3'd4; qe6.push_back(4);
        step();
        sel6 = 3'd5; q6.push_back('{canal: 3'd5, dado: 8'h15, gap: -1});
        step();
        modo6 = 1'b1; mask6 = 6'h00;
        step();

        // T1: manual back-to-back 3 -> 5 -> 0
        modo8 = 1'b0; mask8 = 8'hFF; sel8 = 3'd3; esp8(3'd3, 8'h13, -1);
        step();
        sel8 = 3'd5; esp8(3'd5, 8'h15, 0);
        step();
        sel8 = 3'd0; esp8(3'd0, 8'h10, 0);
        step();
        modo8 = 1'b1; mask8 = 8'h00;
        repeat (2) step();

        // T2: backpressure holds ch2 while selector moves to 6
        modo8 = 1'b0; mask8 = 8'hFF; sel8 = 3'd2; esp8(3'd2, 8'h12, -1);
        step();
        pronta8 = 1'b0; sel8 = 3'd6; esp8(3'd6, 8'h16, 0);
        repeat (4) step();
        pronta8 = 1'b1;
        step();
        modo8 = 1'b1; mask8 = 8'h00;
        repeat (2) step();

        // T3: scan 1010_0101 with dwell 2
        perm8 = 8'd2; mask8 = 8'b1010_0101;
        esp8(3'd0, 8'h10, -1); esp8(3'd2, 8'h12, 2); esp8(3'd5, 8'h15, 2);
        esp8(3'd7, 8'h17, 2);  esp8(3'd0, 8'h10, 2);
        espera_fila();
        mask8 = 8'h00;
        repeat (4) step();

        // T5: empty mask idles, then only channel 7 with dwell 1
        perm8 = 8'd1;
        repeat (5) step();
        mask8 = 8'h80;
        esp8(3'd7, 8'h17, -1); esp8(3'd7, 8'h17, 1); esp8(3'd7, 8'h17, 1);
        espera_fila();
        mask8 = 8'h00;
        repeat (3) step();

        // T6a: async reset in the middle of a dwell
        perm8 = 8'd3; mask8 = 8'b1010_0101; esp8(3'd0, 8'h10, -1);
        espera_fila();
        #2;
        ver_reset = 1'b1;
        rst_n = 1'b0;
        mask8 = 8'h00;
        step();
        rst_n = 1'b1;
        ver_reset = 1'b0;

        // T6b: async reset while a word waits for the consumer
        pronta8 = 1'b0; mask8 = 8'b1010_0101; esp8(3'd0, 8'h10, -1);
        espera_fila();
        #2;
        ver_reset = 1'b1;
        rst_n = 1'b0;
        mask8 = 8'h00;
        step();
        rst_n = 1'b1;
        ver_reset = 1'b0;
        pronta8 = 1'b1; mask8 = 8'b1010_0101; esp8(3'd0, 8'h10, -1);
        espera_fila();
        mask8 = 8'h00;
        repeat (6) step();

        fim = 1'b1;
        for (int c = 0; c < 10 && !done; c++) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_multiplexador_varredura
`default_nettype wire
